ls_responder: RTL

- Local-store responder for the SPU multicycle datapath; the memory-side end of the controller's memread/memwrite requests.
- Accepts word (instruction fetch, 32-bit) and quadword (LQX/STQX, 128-bit) requests over a valid/ready handshake.
- Serialises each request into 32-bit beats on a single-port synchronous SRAM and returns one response per request.
- Sits between the controller/datapath and the local-store SRAM macro.

---
 rtl/ls_pkg.sv | 32 +++
 rtl/ls_beat_pack.sv | 38 +++
 rtl/ls_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ls_pkg.sv
// Local-store responder shared types and constants.
// State encoding, beat geometry and alignment masks.
package ls_pkg;

   localparam int LS_BEAT_W   = 32;
   localparam int LS_QW_W     = 128;
   localparam int LS_BEATS_QW = 4;
   localparam int LS_SLOT_W   = 2;

   localparam logic [3:0] LS_WORD_MASK = 4'h3;
   localparam logic [3:0] LS_QW_MASK   = 4'hF;

   // Word requests live in the low slot so a single beat lands in [31:0].
   localparam logic [LS_SLOT_W-1:0] LS_WORD_SLOT = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      LAST,
      RESP
   } ls_state_e;

   function automatic logic ls_misaligned(
      input logic       qw,
      input logic [3:0] lsb
   );
      logic [3:0] mask;
      mask = qw ? LS_QW_MASK : LS_WORD_MASK;
      return (lsb & mask) != 4'h0;
   endfunction

endpackage

// File: rtl/ls_beat_pack.sv
// Big-endian 128-bit <-> 32-bit beat slicing for the local store.
// Slot 0 is data[127:96], slot 3 is data[31:0].
module ls_beat_pack
   import ls_pkg::*;
(
   input  logic [LS_SLOT_W-1:0] wr_slot_i,
   input  logic [LS_QW_W-1:0]   wdata_i,
   output logic [LS_BEAT_W-1:0] wbeat_o,
   input  logic                 ins_en_i,
   input  logic [LS_SLOT_W-1:0] ins_slot_i,
   input  logic [LS_BEAT_W-1:0] rbeat_i,
   input  logic [LS_QW_W-1:0]   rdata_i,
   output logic [LS_QW_W-1:0]   rdata_o
);

   always_comb begin
      wbeat_o = '0;
      unique case (wr_slot_i)
         2'd0: wbeat_o = wdata_i[127:96];
         2'd1: wbeat_o = wdata_i[95:64];
         2'd2: wbeat_o = wdata_i[63:32];
         2'd3: wbeat_o = wdata_i[31:0];
      endcase
   end

   always_comb begin
      rdata_o = rdata_i;
      if (ins_en_i) begin
         unique case (ins_slot_i)
            2'd0: rdata_o[127:96] = rbeat_i;
            2'd1: rdata_o[95:64]  = rbeat_i;
            2'd2: rdata_o[63:32]  = rbeat_i;
            2'd3: rdata_o[31:0]   = rbeat_i;
         endcase
      end
   end

endmodule

// File: rtl/ls_responder.sv
// Local-store responder: serialises word/quadword requests into
// 32-bit beats on a single-port synchronous SRAM.
module ls_responder
   import ls_pkg::*;
#(
   parameter int ADDR_W = 18
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic                 req_qw,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [LS_QW_W-1:0]   req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [LS_QW_W-1:0]   rsp_data,
   output logic                 rsp_err,
   output logic                 sram_en,
   output logic                 sram_we,
   output logic [ADDR_W-3:0]    sram_addr,
   output logic [LS_BEAT_W-1:0] sram_wdata,
   input  logic [LS_BEAT_W-1:0] sram_rdata
);

   ls_state_e state_q, state_d;

   logic [LS_SLOT_W-1:0] beat_q, beat_d;
   logic [ADDR_W-3:0]    waddr_q, waddr_d;
   logic                 write_q, write_d;
   logic                 qw_q, qw_d;
   logic                 err_q, err_d;
   logic [LS_QW_W-1:0]   wdata_q, wdata_d;
   logic [LS_QW_W-1:0]   rdata_q, rdata_d;
   logic                 pend_q, pend_d;
   logic [LS_SLOT_W-1:0] pslot_q, pslot_d;

   logic [LS_SLOT_W-1:0] slot;
   logic [LS_BEAT_W-1:0] wbeat;
   logic [LS_QW_W-1:0]   rdata_ins;
   logic                 last_beat;

   assign slot      = qw_q ? beat_q : LS_WORD_SLOT;
   assign last_beat = ~qw_q | (beat_q == LS_SLOT_W'(LS_BEATS_QW - 1));

   ls_beat_pack u_pack (
      .wr_slot_i  (slot),
      .wdata_i    (wdata_q),
      .wbeat_o    (wbeat),
      .ins_en_i   (pend_q),
      .ins_slot_i (pslot_q),
      .rbeat_i    (sram_rdata),
      .rdata_i    (rdata_q),
      .rdata_o    (rdata_ins)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         waddr_q <= '0;
         write_q <= 1'b0;
         qw_q    <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         pend_q  <= 1'b0;
         pslot_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         waddr_q <= waddr_d;
         write_q <= write_d;
         qw_q    <= qw_d;
         err_q   <= err_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         pend_q  <= pend_d;
         pslot_q <= pslot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      waddr_d = waddr_q;
      write_d = write_q;
      qw_d    = qw_q;
      err_d   = err_q;
      wdata_d = wdata_q;
      rdata_d = rdata_ins;
      pend_d  = 1'b0;
      pslot_d = slot;

      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_data   = '0;
      rsp_err    = 1'b0;
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               waddr_d = req_addr[ADDR_W-1:2];
               write_d = req_write;
               qw_d    = req_qw;
               wdata_d = req_wdata;
               beat_d  = '0;
               rdata_d = '0;
               if (ls_misaligned(req_qw, req_addr[3:0])) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            sram_en    = 1'b1;
            sram_we    = write_q;
            // Aligned base has zero low bits, so OR never carries.
            sram_addr  = waddr_q | {{(ADDR_W-4){1'b0}}, beat_q};
            sram_wdata = write_q ? wbeat : '0;
            pend_d     = ~write_q;
            if (last_beat) begin
               beat_d  = '0;
               state_d = LAST;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         LAST: begin
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_data  = rdata_q;
            rsp_err   = err_q;
            if (rsp_ready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
      endcase
   end

endmodule
